// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop checker: code constants, FSM encoding
// and the mapping from sequence position to JK code.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    localparam logic [7:0] ERR_MAX = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Run order within one pass: HOLD, SET, RESET, TOGGLE.
    function automatic logic [1:0] code_of(input logic [1:0] idx);
        logic [1:0] code;
        case (idx)
            2'd0:    code = JK_HOLD;
            2'd1:    code = JK_SET;
            2'd2:    code = JK_RESET;
            default: code = JK_TOGGLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/jk_ff_checker_if.sv
// Bus between the checker (drives jk, master) and the flop under test (returns q, slave).
interface jk_ff_checker_if;
    logic [1:0] jk;
    logic       q;

    modport master (output jk, input q);
    modport slave  (input jk, output q);
endinterface

// File: rtl/jk_ref_ff.sv
// Reference JK flop that runs in lockstep with the flop under test.
module jk_ref_ff
    import jk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] jk,
    output logic       exp_q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            exp_q <= 1'b0;
        end else begin
            case (jk)
                JK_SET:    exp_q <= 1'b1;
                JK_RESET:  exp_q <= 1'b0;
                JK_TOGGLE: exp_q <= ~exp_q;
                default:   exp_q <= exp_q;
            endcase
        end
    end

endmodule

// File: rtl/jk_ff_checker.sv
// Stimulus sequencer and checker for an external JK flop: drives the code sequence,
// compares q against a reference flop each cycle and reports an error count and pass flag.
module jk_ff_checker
    import jk_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int NUM_PASSES  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    jk_ff_checker_if.master        bus,
    output logic                   exp_q,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [7:0]             err_cnt,
    output state_t                 state
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int PW = (NUM_PASSES  > 1) ? $clog2(NUM_PASSES)  : 1;

    state_t          state_r, state_next;
    logic [HW-1:0]   hold_r, hold_next;
    logic [1:0]      idx_r, idx_next;
    logic [PW-1:0]   pass_cnt_r, pass_cnt_next;
    logic [1:0]      jk_r, jk_next;
    logic [7:0]      err_r, err_next;
    logic            pass_r, pass_next;
    logic            last_hold, last_step, compare_en, mismatch;

    assign last_hold  = (hold_r == HW'(HOLD_CYCLES - 1));
    assign last_step  = last_hold && (idx_r == 2'd3) && (pass_cnt_r == PW'(NUM_PASSES - 1));
    // q lags jk by one cycle, so the edge ending each RUN/DRAIN cycle checks the previous code.
    assign compare_en = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign mismatch   = (bus.q != exp_q);

    always_comb begin
        state_next    = state_r;
        hold_next     = hold_r;
        idx_next      = idx_r;
        pass_cnt_next = pass_cnt_r;
        jk_next       = JK_HOLD;
        err_next      = err_r;
        pass_next     = pass_r;

        if (compare_en && mismatch && (err_r != ERR_MAX)) begin
            err_next = err_r + 8'd1;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CLEAR;
                    jk_next    = JK_RESET;
                    err_next   = 8'd0;
                    pass_next  = 1'b0;
                end
            end
            ST_CLEAR: begin
                state_next    = ST_RUN;
                hold_next     = '0;
                idx_next      = 2'd0;
                pass_cnt_next = '0;
                jk_next       = code_of(2'd0);
            end
            ST_RUN: begin
                if (last_step) begin
                    state_next = ST_DRAIN;
                end else begin
                    if (last_hold) begin
                        hold_next = '0;
                        idx_next  = idx_r + 2'd1;
                        if (idx_r == 2'd3) begin
                            pass_cnt_next = pass_cnt_r + 1'b1;
                        end
                    end else begin
                        hold_next = hold_r + 1'b1;
                    end
                    jk_next = code_of(idx_next);
                end
            end
            ST_DRAIN: begin
                state_next = ST_DONE;
                pass_next  = (err_next == 8'd0);
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            hold_r     <= '0;
            idx_r      <= 2'd0;
            pass_cnt_r <= '0;
            jk_r       <= JK_HOLD;
            err_r      <= 8'd0;
            pass_r     <= 1'b0;
        end else begin
            state_r    <= state_next;
            hold_r     <= hold_next;
            idx_r      <= idx_next;
            pass_cnt_r <= pass_cnt_next;
            jk_r       <= jk_next;
            err_r      <= err_next;
            pass_r     <= pass_next;
        end
    end

    jk_ref_ff u_ref (
        .clk   (clk),
        .rst   (rst),
        .jk    (jk_r),
        .exp_q (exp_q)
    );

    assign bus.jk  = jk_r;
    assign busy    = (state_r == ST_CLEAR) || (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign done    = (state_r == ST_DONE);
    assign pass    = pass_r;
    assign err_cnt = err_r;
    assign state   = state_r;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Bench for jk_ff_checker: three checker configurations, each driving a behavioural
// JK flop that can be ideal or stuck; results are scoreboarded on every done pulse.
module tb_jk_ff_checker;
    import jk_pkg::*;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start    [N];
    logic [1:0] jk_mon   [N];
    logic       exp_mon  [N];
    logic       busy     [N];
    logic       done     [N];
    logic       pass_o   [N];
    logic [7:0] err_mon  [N];
    state_t     st_mon   [N];
    int         fault    [N];   // 0 ideal, 1 stuck at 0, 2 stuck at 1

    int         cyc      = 0;
    int         n_checks = 0;
    int         n_fails  = 0;
    logic       trace_en = 1'b0;

    // result entry: {instance[1:0], done_edge[15:0], err_cnt[7:0], pass}
    logic [26:0] res_exp_q [$];
    // trace entry: {jk[1:0], exp_q}
    logic [2:0]  trace_exp_q [$];
    logic [26:0] re;
    logic [2:0]  te;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        jk_ff_checker_if bus ();
        logic fq = 1'b0;

        jk_ff_checker #(
            .HOLD_CYCLES ((g == 1) ? 2 : 1),
            .NUM_PASSES  ((g == 2) ? 200 : 1)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start[g]),
            .bus     (bus.master),
            .exp_q   (exp_mon[g]),
            .busy    (busy[g]),
            .done    (done[g]),
            .pass    (pass_o[g]),
            .err_cnt (err_mon[g]),
            .state   (st_mon[g])
        );

        always @(posedge clk) begin
            case (bus.jk)
                2'b10:   fq <= 1'b1;
                2'b01:   fq <= 1'b0;
                2'b11:   fq <= ~fq;
                default: fq <= fq;
            endcase
        end

        assign bus.q     = (fault[g] == 1) ? 1'b0 : (fault[g] == 2) ? 1'b1 : fq;
        assign jk_mon[g] = bus.jk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: pops the trace queue on busy cycles and the result queue on done pulses.
    always @(negedge clk) begin
        if (trace_en && busy[0]) begin
            if (trace_exp_q.size() == 0) begin
                fail_now("trace_extra_cycle");
            end else begin
                te = trace_exp_q.pop_front();
                check("trace_jk", 32'(jk_mon[0]), 32'(te[2:1]));
                check("trace_exp_q", 32'(exp_mon[0]), 32'(te[0]));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                if (res_exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    re = res_exp_q.pop_front();
                    check("done_instance", 32'(i), 32'(re[26:25]));
                    check("done_edge", 32'(cyc), 32'(re[24:9]));
                    check("err_cnt", 32'(err_mon[i]), 32'(re[8:1]));
                    check("pass", 32'(pass_o[i]), 32'(re[0]));
                end
            end
        end
    end

    task automatic do_start(input int id, input int r, input logic [7:0] err, input logic p);
        @(negedge clk);
        start[id] = 1'b1;
        res_exp_q.push_back({2'(id), 16'(cyc + 1 + r + 2), err, p});
        @(negedge clk);
        start[id] = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int k;
        k = 0;
        while ((busy[id] || done[id]) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) fail_now("wait_idle_timeout");
        @(negedge clk);
    endtask

    initial begin
        int k;
        for (int i = 0; i < N; i++) begin
            start[i] = 1'b0;
            fault[i] = 0;
        end

        repeat (3) @(negedge clk);
        check("rst_jk", 32'(jk_mon[0]), 32'(2'b00));
        check("rst_exp_q", 32'(exp_mon[0]), 0);
        check("rst_busy", 32'(busy[0]), 0);
        check("rst_done", 32'(done[0]), 0);
        check("rst_pass", 32'(pass_o[0]), 0);
        check("rst_err_cnt", 32'(err_mon[0]), 0);
        check("rst_state", 32'(st_mon[0]), 32'(ST_IDLE));
        rst = 1'b1;
        @(negedge clk);

        // Ideal flop, traced: jk 01,00,10,01,11,00 with exp_q 0,0,0,1,0,1 on the busy cycles.
        trace_exp_q.push_back({2'b01, 1'b0});
        trace_exp_q.push_back({2'b00, 1'b0});
        trace_exp_q.push_back({2'b10, 1'b0});
        trace_exp_q.push_back({2'b01, 1'b1});
        trace_exp_q.push_back({2'b11, 1'b0});
        trace_exp_q.push_back({2'b00, 1'b1});
        trace_en = 1'b1;
        do_start(0, 4, 8'd0, 1'b1);
        wait_idle(0);
        trace_en = 1'b0;

        fault[0] = 1;
        do_start(0, 4, 8'd2, 1'b0);
        wait_idle(0);

        fault[0] = 2;
        do_start(0, 4, 8'd3, 1'b0);
        wait_idle(0);

        fault[0] = 0;
        do_start(1, 8, 8'd0, 1'b1);
        wait_idle(1);

        fault[2] = 1;
        do_start(2, 800, 8'd255, 1'b0);
        wait_idle(2);

        // Reset mid-run: rst sampled low at e3 while a stuck-at-1 flop has logged one error.
        fault[0] = 2;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_err_before_rst", 32'(err_mon[0]), 1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy[0]), 0);
        check("mid_rst_jk", 32'(jk_mon[0]), 0);
        check("mid_rst_exp_q", 32'(exp_mon[0]), 0);
        check("mid_rst_err_cnt", 32'(err_mon[0]), 0);
        rst = 1'b1;
        fault[0] = 0;
        do_start(0, 4, 8'd0, 1'b1);
        wait_idle(0);

        // start during RUN and during DONE must both be ignored.
        do_start(0, 4, 8'd0, 1'b1);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        k = 0;
        while (!done[0] && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail_now("done_timeout");
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("ignored_start_busy", 32'(busy[0]), 0);
        check("ignored_start_state", 32'(st_mon[0]), 32'(ST_IDLE));

        check("results_outstanding", 32'(res_exp_q.size()), 0);
        check("trace_outstanding", 32'(trace_exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/jk_ff_checker.md
# jk_ff_checker

Self-checking stimulus sequencer for the JK flip-flop. It drives the `jk` inputs of an external JK flop under test through the fixed code sequence hold / set / reset / toggle. It runs an internal reference flop in lockstep, compares the DUT `q` every cycle and reports an error count and a pass flag. It sits on the opposite side of the flop interface from the flop itself: it is the driver and checker, the flop is the responder, and it makes flop checking synthesizable and repeatable on-chip.

## Interface
- `HOLD_CYCLES`, default 1: clock cycles each JK code is held (≥1).
- `NUM_PASSES`, default 1: repetitions of the 4-code sequence (≥1).
- `clk`  in  1  rising-edge clock; sole clock domain.
- `rst`  in  1  reset; synchronous, active-low (sampled on `clk` rising edge).
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `q`  in  1  output of flop under test (same `clk`).
- `jk`  out  2  registered drive to flop; `jk[1]`=J, `jk[0]`=K.
- `exp_q`  out  1  reference model state.
- `busy`  out  1  high from CLEAR through DRAIN.
- `done`  out  1  one-cycle pulse in DONE.
- `pass`  out  1  valid with/after `done`: `err_cnt==0`; held until next `start`.
- `err_cnt`  out  8  mismatch count, saturating at 255; cleared on `start`.

## Operation
- Codes: HOLD=00, SET=10, RESET=01, TOGGLE=11. Run order: HOLD, SET, RESET, TOGGLE, each for `HOLD_CYCLES` cycles, repeated `NUM_PASSES` times. R = 4·HOLD_CYCLES·NUM_PASSES.
- Model: `exp_q <= J&~K ? 1 : ~J&K ? 0 : J&K ? ~exp_q : exp_q`, updated on the same edge as the DUT, using the current `jk`.
- FSM states:
  - IDLE: `jk`=00. If `start` is high, go to CLEAR and clear `err_cnt` and `pass`.
  - CLEAR: 1 cycle, `jk`=RESET, which forces DUT and model to 0. Go to RUN.
  - RUN: R cycles stepping codes, using a hold counter, code index (2 bits) and pass counter. Go to DRAIN after the last cycle.
  - DRAIN: 1 cycle, `jk`=HOLD. Go to DONE.
  - DONE: 1 cycle, `done`=1, `pass`=(err_cnt==0). Go to IDLE.
- Compare: on every rising edge that ends a RUN or DRAIN cycle, if `q != exp_q`, increment `err_cnt` (saturating). This gives R+1 compares per run; the first compare checks the CLEAR result.
- `start` is ignored outside IDLE. `start` in DONE is not queued.
- `rst` low at any edge, including mid-run, sends the FSM to IDLE and drives all outputs to their reset values. `rst` does not reset the external flop; its own reset is separate.

## Timing
- Reset values: `jk`=00, `exp_q`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0.
- Edge e0 samples `start`. CLEAR is visible after e0. RUN spans e1..e(R). DRAIN is visible after e(R+1). `done` is high for exactly the cycle after e(R+2).
- `err_cnt` is final when `done` is high. `pass` updates on the edge that enters DONE.
- `jk`, `exp_q` and status outputs are registered; no combinational path exists from `q` or `start` to any output.
- The DUT must respond to `jk` on the same edge as the model. `q` is sampled one cycle after the code that produced it.

## Structure
- Shared package `jk_pkg`:
  - code constants `JK_HOLD`, `JK_SET`, `JK_RESET`, `JK_TOGGLE`;
  - FSM state encoding `ST_IDLE`, `ST_CLEAR`, `ST_RUN`, `ST_DRAIN`, `ST_DONE`;
  - `ERR_MAX`=8'd255.
- Sub-module `jk_ref_ff`: the reference flop (clk, rst, jk → exp_q), synchronous active-low reset to 0. It is instantiated once.
- The top level holds the FSM, sequence counters and the compare/error counter.

## Test plan
- Ideal JK flop, HOLD_CYCLES=1, NUM_PASSES=1, `start` at e0 → `jk` sequence 01,00,10,01,11,00; `exp_q` after each code 0,0,1,0,1,1; `done` in the cycle after e6; `err_cnt`=0; `pass`=1.
- `q` stuck at 0, same parameters → `err_cnt`=2, `pass`=0. `q` stuck at 1 → `err_cnt`=3, `pass`=0.
- Ideal flop, HOLD_CYCLES=2 → each code is held 2 cycles; 9 compares; `done` in the cycle after e10; `err_cnt`=0.
- `q` stuck at 0, NUM_PASSES=200 → `err_cnt` saturates at 255 with no wrap; `pass`=0.
- Reset mid-run: drive `rst`=0 at e3 → `busy`, `jk`, `exp_q` and `err_cnt` are all 0 the next cycle. A new `start` then runs cleanly to `pass`=1.
- `start` pulsed during RUN and during DONE → ignored. A single `done` pulse per accepted `start`.
